// File: rtl/e203_itcm_icb_rsp_model.sv
// ICB responder standing in for the ITCM SRAM: 64-bit word array, 2-entry response
// buffer, and LFSR-timed OK/ERR windows that inject read errors when the core has MIE set.
module e203_itcm_icb_rsp_model #(
   parameter int          AW   = 16,
   parameter int          DP   = 8192,
   parameter logic [15:0] SEED = 16'hACE1
) (
   input  logic          clk,
   input  logic          rst_n,
   input  logic          icb_cmd_valid,
   output logic          icb_cmd_ready,
   input  logic [AW-1:0] icb_cmd_addr,
   input  logic          icb_cmd_read,
   input  logic [63:0]   icb_cmd_wdata,
   input  logic [7:0]    icb_cmd_wmask,
   output logic          icb_rsp_valid,
   input  logic          icb_rsp_ready,
   output logic [63:0]   icb_rsp_rdata,
   output logic          icb_rsp_err,
   input  logic          inj_en,
   input  logic          inj_stop,
   input  logic          core_mie,
   output logic          inj_phase,
   output logic [15:0]   inj_err_cnt
);
   localparam int IW = (DP > 1) ? $clog2(DP) : 1;

   typedef enum logic {ST_OK, ST_ERR} inj_st_e;

   logic [63:0]      mem [0:DP-1];
   logic [AW-4:0]    idx;
   logic [IW-1:0]    midx;
   logic             in_range, cmd_hs, rsp_hs, inj_err;
   logic [63:0]      push_rdata;
   logic             push_err;
   logic [1:0]       occ;
   logic             rd_ptr, wr_ptr;
   logic [1:0][63:0] buf_rdata;
   logic [1:0]       buf_err;
   logic [15:0]      lfsr;
   logic             stop_r;
   inj_st_e          state, state_nxt;
   logic [7:0]       cnt, cnt_nxt, ok_len, err_len;
   logic             unused_addr_lsb;

   assign unused_addr_lsb = ^icb_cmd_addr[2:0];
   assign idx      = icb_cmd_addr[AW-1:3];
   assign midx     = IW'(idx);
   assign in_range = (32'(idx) < DP);

   assign icb_cmd_ready = (occ != 2'd2);
   assign icb_rsp_valid = (occ != 2'd0);
   assign cmd_hs        = icb_cmd_valid & icb_cmd_ready;
   assign rsp_hs        = icb_rsp_valid & icb_rsp_ready;
   assign icb_rsp_rdata = icb_rsp_valid ? buf_rdata[rd_ptr] : 64'd0;
   assign icb_rsp_err   = icb_rsp_valid & buf_err[rd_ptr];

   assign inj_phase = (state == ST_ERR);
   assign inj_err   = inj_phase & inj_en & ~stop_r & core_mie;

   // Memory has no reset so preloaded contents survive rst_n.
   always_ff @(posedge clk) begin
      if (rst_n && cmd_hs && !icb_cmd_read && in_range)
         for (int i = 0; i < 8; i++)
            if (icb_cmd_wmask[i]) mem[midx][i*8 +: 8] <= icb_cmd_wdata[i*8 +: 8];
   end

   always_comb begin
      push_rdata = 64'd0;
      push_err   = 1'b0;
      if (!in_range)
         push_err = 1'b1;
      else if (icb_cmd_read) begin
         push_rdata = mem[midx];
         push_err   = inj_err;
      end
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         occ         <= 2'd0;
         rd_ptr      <= 1'b0;
         wr_ptr      <= 1'b0;
         buf_rdata   <= '0;
         buf_err     <= '0;
         inj_err_cnt <= 16'd0;
      end else begin
         if (cmd_hs) begin
            buf_rdata[wr_ptr] <= push_rdata;
            buf_err[wr_ptr]   <= push_err;
            wr_ptr            <= ~wr_ptr;
         end
         if (rsp_hs) rd_ptr <= ~rd_ptr;
         occ <= occ + {1'b0, cmd_hs} - {1'b0, rsp_hs};
         if (cmd_hs && icb_cmd_read && in_range && inj_err && inj_err_cnt != 16'hFFFF)
            inj_err_cnt <= inj_err_cnt + 16'd1;
      end
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         lfsr   <= SEED;
         stop_r <= 1'b0;
         state  <= ST_OK;
         cnt    <= 8'(SEED[3:0]) + 8'd1;
      end else begin
         lfsr  <= {lfsr[14:0], lfsr[15] ^ lfsr[13] ^ lfsr[12] ^ lfsr[10]};
         state <= state_nxt;
         cnt   <= cnt_nxt;
         if (inj_stop) stop_r <= 1'b1;
      end
   end

   // Window lengths come from the pre-advance LFSR value; stop pins the FSM in OK.
   always_comb begin
      ok_len    = 8'(lfsr[3:0]) + 8'd1;
      err_len   = 8'(lfsr[10:4]) + 8'd1;
      state_nxt = state;
      cnt_nxt   = cnt - 8'd1;
      if (stop_r || inj_stop) begin
         state_nxt = ST_OK;
         cnt_nxt   = ok_len;
      end else if (cnt == 8'd1) begin
         if (state == ST_OK) begin
            state_nxt = ST_ERR;
            cnt_nxt   = err_len;
         end else begin
            state_nxt = ST_OK;
            cnt_nxt   = ok_len;
         end
      end
   end
endmodule

// File: tb/tb_e203_itcm_icb_rsp_model.sv
// Directed bench for the ITCM ICB responder: data path, backpressure, injection gating,
// stop, reset reproducibility and out-of-range errors.
module tb_e203_itcm_icb_rsp_model;
   localparam int          AW   = 16;
   localparam int          DP   = 4096;
   localparam logic [15:0] SEED = 16'hACE1;

   logic          clk = 1'b0;
   logic          rst_n = 1'b0;
   logic          cmd_valid = 1'b0, cmd_ready, cmd_read = 1'b1;
   logic [AW-1:0] addr = '0;
   logic [63:0]   wdata = '0;
   logic [7:0]    wmask = '0;
   logic          rsp_valid, rsp_ready = 1'b1, rsp_err;
   logic [63:0]   rsp_rdata;
   logic          inj_en = 1'b0, inj_stop = 1'b0, core_mie = 1'b0, inj_phase;
   logic [15:0]   inj_err_cnt;

   int n_chk = 0, n_fail = 0;
   int m_lfsr, m_st, m_cnt;

   always #5 clk = ~clk;

   e203_itcm_icb_rsp_model #(.AW(AW), .DP(DP), .SEED(SEED)) dut (
      .clk(clk), .rst_n(rst_n),
      .icb_cmd_valid(cmd_valid), .icb_cmd_ready(cmd_ready), .icb_cmd_addr(addr),
      .icb_cmd_read(cmd_read), .icb_cmd_wdata(wdata), .icb_cmd_wmask(wmask),
      .icb_rsp_valid(rsp_valid), .icb_rsp_ready(rsp_ready), .icb_rsp_rdata(rsp_rdata),
      .icb_rsp_err(rsp_err), .inj_en(inj_en), .inj_stop(inj_stop), .core_mie(core_mie),
      .inj_phase(inj_phase), .inj_err_cnt(inj_err_cnt)
   );

   task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s got=%h exp=%h", tag, got, exp);
      end
   endtask

   // Reference window generator, counting down to zero rather than comparing at one.
   task automatic m_reset();
      m_lfsr = int'(SEED);
      m_st   = 0;
      m_cnt  = (m_lfsr & 15) + 1;
   endtask

   task automatic m_step();
      int old, fb;
      old = m_lfsr;
      fb  = ((old >> 15) ^ (old >> 13) ^ (old >> 12) ^ (old >> 10)) & 1;
      m_cnt--;
      if (m_cnt == 0) begin
         if (m_st == 0) begin m_st = 1; m_cnt = ((old >> 4) & 127) + 1; end
         else           begin m_st = 0; m_cnt = (old & 15) + 1; end
      end
      m_lfsr = ((old << 1) | fb) & 16'hFFFF;
   endtask

   // Enters and leaves on a negedge; compares inj_phase against the model each cycle.
   task automatic phase_run(input int n, output int bad);
      bad = 0;
      for (int i = 0; i < n; i++) begin
         if (inj_phase !== m_st[0]) bad++;
         m_step();
         @(negedge clk);
      end
   endtask

   task automatic do_reset();
      @(posedge clk); #1;
      rst_n = 1'b0; cmd_valid = 1'b0; rsp_ready = 1'b1; inj_stop = 1'b0;
      repeat (2) @(posedge clk);
      #1 rst_n = 1'b1;
      m_reset();
      @(negedge clk);
   endtask

   // One command with rsp_ready high; returns the response plus the phase and a
   // latency flag (idle in the handshake cycle, valid exactly one cycle later).
   task automatic op(input logic rd, input logic [AW-1:0] a, input logic [63:0] wd,
                     input logic [7:0] wm, output logic [63:0] rdat, output logic er,
                     output logic ph, output logic lat_ok);
      @(posedge clk); #1;
      cmd_valid = 1'b1; cmd_read = rd; addr = a; wdata = wd; wmask = wm; rsp_ready = 1'b1;
      @(negedge clk);
      ph = inj_phase;
      lat_ok = cmd_ready & ~rsp_valid;
      @(posedge clk); #1 cmd_valid = 1'b0;
      @(negedge clk);
      lat_ok = lat_ok & rsp_valid;
      rdat = rsp_rdata;
      er = rsp_err;
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog got=timeout exp=finish");
      $fatal(1, "watchdog");
   end

   initial begin
      logic [63:0] rd;
      logic er, ph, ok;
      int bad, nerr, mism, werr, phs;
      logic [15:0] cnt0;

      dut.mem[20] = 64'd0;
      dut.mem[30] = 64'hA0A0_0000_0000_0001;
      dut.mem[31] = 64'hB1B1_0000_0000_0002;
      dut.mem[32] = 64'hC2C2_0000_0000_0003;

      do_reset();
      chk("rst_rsp_valid", 64'(rsp_valid), 64'd0);
      chk("rst_rsp_err",   64'(rsp_err),   64'd0);
      chk("rst_rsp_rdata", rsp_rdata,      64'd0);
      chk("rst_cmd_ready", 64'(cmd_ready), 64'd1);
      chk("rst_inj_phase", 64'(inj_phase), 64'd0);
      chk("rst_err_cnt",   64'(inj_err_cnt), 64'd0);
      phase_run(300, bad);
      chk("phase_seq", 64'(bad), 64'd0);

      op(1'b0, 16'h0080, 64'h1122334455667788, 8'hFF, rd, er, ph, ok);
      chk("wr_rdata", rd, 64'd0);
      chk("wr_err", 64'(er), 64'd0);
      op(1'b1, 16'h0080, 64'd0, 8'h00, rd, er, ph, ok);
      chk("rd_rdata", rd, 64'h1122334455667788);
      chk("rd_err", 64'(er), 64'd0);
      chk("rd_latency", 64'(ok), 64'd1);

      op(1'b0, 16'h00A0, 64'hFFFF_FFFF_FFFF_FFFF, 8'h0F, rd, er, ph, ok);
      op(1'b1, 16'h00A0, 64'd0, 8'h00, rd, er, ph, ok);
      chk("mask_rdata", rd, 64'h0000_0000_FFFF_FFFF);

      @(posedge clk); #1;
      rsp_ready = 1'b0; cmd_valid = 1'b1; cmd_read = 1'b1; addr = 16'h00F0;
      @(negedge clk); chk("bp_rdy0", 64'(cmd_ready), 64'd1);
      @(posedge clk); #1 addr = 16'h00F8;
      @(negedge clk); chk("bp_rdy1", 64'(cmd_ready), 64'd1);
      @(posedge clk); #1 addr = 16'h0100;
      @(negedge clk); chk("bp_full", 64'(cmd_ready), 64'd0);
      chk("bp_hold", rsp_rdata, 64'hA0A0_0000_0000_0001);
      @(posedge clk); #1 rsp_ready = 1'b1;
      @(negedge clk); chk("bp_nobypass", 64'(cmd_ready), 64'd0);
      chk("bp_rsp0", rsp_rdata, 64'hA0A0_0000_0000_0001);
      @(posedge clk); #1;
      @(negedge clk); chk("bp_accept", 64'(cmd_ready), 64'd1);
      chk("bp_rsp1", rsp_rdata, 64'hB1B1_0000_0000_0002);
      @(posedge clk); #1 cmd_valid = 1'b0;
      @(negedge clk); chk("bp_rsp2", rsp_rdata, 64'hC2C2_0000_0000_0003);
      @(posedge clk); #1;
      @(negedge clk); chk("bp_empty", 64'(rsp_valid), 64'd0);

      inj_en = 1'b1; core_mie = 1'b1;
      cnt0 = inj_err_cnt;
      op(1'b1, 16'h8000, 64'd0, 8'h00, rd, er, ph, ok);
      chk("oor_err", 64'(er), 64'd1);
      chk("oor_rdata", rd, 64'd0);
      chk("oor_cnt", 64'(inj_err_cnt), 64'(cnt0));

      core_mie = 1'b0; nerr = 0;
      for (int i = 0; i < 2000; i++) begin
         op(1'b1, 16'h0080, 64'd0, 8'h00, rd, er, ph, ok);
         if (er) nerr++;
      end
      chk("mie0_errs", 64'(nerr), 64'd0);

      core_mie = 1'b1; nerr = 0; mism = 0; werr = 0; cnt0 = inj_err_cnt;
      for (int i = 0; i < 2000; i++) begin
         if (i % 4 == 3) begin
            op(1'b0, 16'h00C0, 64'(i), 8'hFF, rd, er, ph, ok);
            if (er) werr++;
         end else begin
            op(1'b1, 16'h0080, 64'd0, 8'h00, rd, er, ph, ok);
            if (er !== ph) mism++;
            if (er) nerr++;
            if (rd !== 64'h1122334455667788) mism++;
         end
      end
      chk("inj_match_phase", 64'(mism), 64'd0);
      chk("inj_wr_errs", 64'(werr), 64'd0);
      chk("inj_seen", 64'(nerr != 0), 64'd1);
      chk("inj_err_cnt", 64'(inj_err_cnt - cnt0), 64'(nerr));

      @(posedge clk); #1 inj_stop = 1'b1;
      @(posedge clk); #1 inj_stop = 1'b0;
      cnt0 = inj_err_cnt; nerr = 0; phs = 0;
      for (int i = 0; i < 300; i++) begin
         op(1'b1, 16'h0080, 64'd0, 8'h00, rd, er, ph, ok);
         if (er) nerr++;
         if (ph) phs++;
      end
      chk("stop_phase", 64'(phs), 64'd0);
      chk("stop_errs", 64'(nerr), 64'd0);
      chk("stop_cnt", 64'(inj_err_cnt), 64'(cnt0));

      do_reset();
      chk("rst2_err_cnt", 64'(inj_err_cnt), 64'd0);
      op(1'b1, 16'h0080, 64'd0, 8'h00, rd, er, ph, ok);
      chk("mem_persist", rd, 64'h1122334455667788);
      do_reset();
      phase_run(400, bad);
      chk("phase_repro", 64'(bad), 64'd0);

      $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
      $finish;
   end
endmodule
